// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller:
//   forwarding select encodings, the MDU occupancy FSM state type and
//   the default register index width.
package hazard_ctrl_pkg;

    localparam int unsigned REG_AW_DEF = 5;

    // EX operand source selects
    localparam logic [1:0] FWD_REG   = 2'b00;  // register file value
    localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM pipeline register
    localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB pipeline register

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Purely combinational forwarding comparator for one EX operand.
//   Ports:
//     src_i           EX-stage source register index
//     mem_rd_i        MEM-stage destination index
//     mem_reg_write_i MEM stage writes a register
//     wb_rd_i         WB-stage destination index
//     wb_reg_write_i  WB stage writes a register
//     sel_o           operand select (FWD_REG / FWD_EXMEM / FWD_MEMWB)
//   Register 0 never forwards; the younger EX/MEM result wins over MEM/WB.
module hazard_fwd_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_reg_write_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_reg_write_i,
    output logic [1:0]        sel_o
);

    always_comb begin
        sel_o = FWD_REG;
        if (src_i != '0) begin
            if (mem_reg_write_i && (mem_rd_i == src_i)) begin
                sel_o = FWD_EXMEM;
            end else if (wb_reg_write_i && (wb_rd_i == src_i)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller for the 5-stage datapath. Produces the
//   hold/flush controls for PC, IF_ID and ID/EX plus the EX operand
//   forwarding selects, and tracks multi-cycle MDU occupancy.
//   Ports:
//     clk, rst                 clock (rising edge), async active-low reset
//     id_rs/id_rt, id_use_*    ID-stage sources and their use flags
//     id_use_hilo, id_mdu_op   ID instruction reads HI/LO / is mult-div
//     ex_rs/ex_rt/ex_rd, ex_*  EX-stage indices, write/load/branch/MDU start
//     mem_rd/mem_reg_write     MEM-stage destination
//     wb_rd/wb_reg_write       WB-stage destination
//     pc_hold, if_id_hold      hold PC / IF_ID
//     if_id_flush, id_ex_flush bubble IF_ID / ID/EX
//     fwd_a, fwd_b             EX operand selects
//     mdu_busy                 MDU still occupied
//   Configuration macro: HAZARD_CTRL_FORWARDING_EN
//     defined   - forwarding active, only load-use RAW stalls
//     undefined - selects tied to register file, any RAW on an EX or MEM
//                 producer stalls until the producer reaches WB
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned REG_AW  = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_use_hilo,
    input  logic              id_mdu_op,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              ex_mdu_start,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mdu_busy
);

    // Counter must hold MDU_LAT-1; keep at least one bit for MDU_LAT <= 2.
    localparam int unsigned CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 1);

    hz_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic ex_hit, mem_hit, raw_stall, mdu_stall, stall;

    // ID instruction reads a given nonzero producer register
    function automatic logic id_reads(input logic [REG_AW-1:0] r,
                                      input logic [REG_AW-1:0] rs,
                                      input logic [REG_AW-1:0] rt,
                                      input logic use_rs,
                                      input logic use_rt);
        return (r != '0) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
    endfunction

    // ---------------- MDU occupancy FSM ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (ex_mdu_start && (MDU_LAT > 1)) begin
                    state_d = MDU_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            MDU_WAIT: begin
                // A second start while busy restarts the full wait.
                if (ex_mdu_start) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == CW'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mdu_busy = (state_q == MDU_WAIT);

    // ---------------- RAW detection and forwarding ----------------
    assign ex_hit  = ex_reg_write  && id_reads(ex_rd,  id_rs, id_rt, id_use_rs, id_use_rt);
    assign mem_hit = mem_reg_write && id_reads(mem_rd, id_rs, id_rt, id_use_rs, id_use_rt);

`ifdef HAZARD_CTRL_FORWARDING_EN
    // Only a load in EX cannot be bypassed in time.
    assign raw_stall = ex_mem_read && ex_hit;

    logic unused_fwd_en;
    assign unused_fwd_en = mem_hit;

    hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .src_i           (ex_rs),
        .mem_rd_i        (mem_rd),
        .mem_reg_write_i (mem_reg_write),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .sel_o           (fwd_a)
    );

    hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .src_i           (ex_rt),
        .mem_rd_i        (mem_rd),
        .mem_reg_write_i (mem_reg_write),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .sel_o           (fwd_b)
    );
`else
    // No bypass paths: wait until the producer is in WB, where the
    // write-before-read register file resolves the dependency.
    assign raw_stall = ex_hit || mem_hit;
    assign fwd_a     = FWD_REG;
    assign fwd_b     = FWD_REG;

    logic unused_fwd_dis;
    assign unused_fwd_dis = ^{ex_rs, ex_rt, wb_rd, wb_reg_write, ex_mem_read};
`endif

    // ---------------- pipeline controls ----------------
    assign mdu_stall = mdu_busy && (id_use_hilo || id_mdu_op);
    assign stall     = raw_stall || mdu_stall;

    // Reset forces all controls low; a taken branch overrides any stall.
    assign pc_hold     = rst && stall && !ex_branch_taken;
    assign if_id_hold  = rst && stall && !ex_branch_taken;
    assign if_id_flush = rst && ex_branch_taken;
    assign id_ex_flush = rst && (ex_branch_taken || stall);

endmodule
